intersection_controller: RTL and testbench
==========================================

# intersection_controller

Sequences a two-approach intersection (A and B) built from traffic-light phases, sharing the single right of way between the two approaches based on latched vehicle/pedestrian requests. It sits above the per-light logic, consumes a one-cycle millisecond tick derived from the chronometer, and drives both lamp sets directly. The controller guarantees minimum green, yellow clearance and an all-red interval on every handover.

## Interface
- GREEN_MIN_MS, 5000: minimum green duration in ms before yielding.
- GREEN_MAX_MS, 10000: maximum green duration when the other approach is waiting; must be ≥ GREEN_MIN_MS.
- YELLOW_MS, 2000: yellow duration in ms.
- ALLRED_MS, 1000: all-red interval in ms.
- MS_W, 16: phase timer width; must hold GREEN_MAX_MS.

- CLK  input  1  system clock (6 MHz domain).
- RST  input  1  reset, asynchronous, active-low.
- EN  input  1  run enable; low suspends sequencing.
- MS_TICK  input  1  one-CLK-cycle pulse per elapsed millisecond.
- REQ_A  input  1  request/presence on approach A, level, synchronous to CLK.
- REQ_B  input  1  request/presence on approach B.
- GREEN_A, YELLOW_A, RED_A  output  1 each  approach A lamps, registered.
- GREEN_B, YELLOW_B, RED_B  output  1 each  approach B lamps, registered.
- PHASE  output  3  current state code, registered.

## Operation
- States/codes: INIT_RED 0, GREEN_A 1, YELLOW_A 2, RED_AB 3, GREEN_B 4, YELLOW_B 5, RED_BA 6, FLASH 7 (only with macro).
- Lamps: GREEN_x→ green x, red other; YELLOW_x→ yellow x, red other; INIT_RED/RED_AB/RED_BA→ both red. Exactly one lamp per approach lit except FLASH.
- Pending flags pend_A/pend_B: set when REQ_x high and controller not in GREEN_x; cleared on the cycle GREEN_x is entered (clear wins over simultaneous set).
- Phase timer: cleared on every state change; increments on MS_TICK while EN high; saturates at GREEN_MAX_MS. "Elapsed" = timer value after the increment.
- INIT_RED → GREEN_A when elapsed = ALLRED_MS.
- GREEN_A: stays indefinitely while pend_B = 0. With pend_B = 1, → YELLOW_A at the first tick where elapsed ≥ GREEN_MIN_MS and REQ_A = 0, or elapsed = GREEN_MAX_MS regardless of REQ_A.
- YELLOW_A → RED_AB at elapsed = YELLOW_MS; RED_AB → GREEN_B at elapsed = ALLRED_MS.
- GREEN_B/YELLOW_B/RED_BA mirror the above with A/B swapped; RED_BA → GREEN_A.
- Simultaneous pend_A and pend_B in a red interval: the fixed rotation decides; no priority logic.

## Timing
- Reset (RST low, immediate): state INIT_RED, PHASE=0, RED_A=RED_B=1, all other lamps 0, timer 0, pend flags 0.
- Reset release mid-operation restarts from INIT_RED; no state is retained.
- Transition: the state register and lamps update on the CLK edge after the MS_TICK cycle that satisfies the exit condition (1-cycle latency); phase lasting D ms spans exactly D ticks.
- REQ sampling: a request is latched on the CLK edge where it is high; a one-cycle pulse suffices.
- MS_TICK while EN low is ignored; a tick coinciding with EN rise counts.
- Without the macro, EN low freezes state, timer and lamps; pend flags keep latching.

## Configuration
- FLASH_YELLOW_EN defined: EN low forces FLASH on the next edge; YELLOW_A=YELLOW_B toggle every 500 ticks (start lit), all greens/reds 0, PHASE=7. EN high → INIT_RED with timer 0; pend flags preserved.
- FLASH_YELLOW_EN undefined: no FLASH state; EN low freezes as in Timing; code 7 never appears.

## Test plan
Parameters GREEN_MIN_MS=5, GREEN_MAX_MS=10, YELLOW_MS=3, ALLRED_MS=2, MS_TICK every 4 CLKs.
- Reset, no requests → PHASE 0 for 2 ticks, then GREEN_A (PHASE 1, GREEN_A=1, RED_B=1) held for 50 ticks.
- 1-cycle REQ_B pulse at tick 1 of GREEN_A, REQ_A low → YELLOW_A after tick 5, RED_AB after 3 more, GREEN_B after 2 more; pend_B cleared.
- REQ_B pending, REQ_A held high → GREEN_A lasts exactly 10 ticks, then YELLOW_A.
- REQ_A and REQ_B pulsed in same cycle during RED_AB → GREEN_B, then GREEN_A after its min + yellow + all-red (5+3+2 ticks).
- EN low for 20 ticks in GREEN_B with pend_A set: no macro → lamps/PHASE frozen, timer resumes; with FLASH_YELLOW_EN → PHASE 7, yellows toggle each 500 ticks, EN high → PHASE 0.
- RST asserted mid YELLOW_A (between clocks) → lamps immediately both red, PHASE 0, before the next CLK edge.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer: min-green / max-green handover with yellow and all-red clearance.
// Optional FLASH_YELLOW_EN: EN low forces a flashing-yellow state instead of freezing.
module intersection_controller #(
  parameter int GREEN_MIN_MS = 5000,
  parameter int GREEN_MAX_MS = 10000,
  parameter int YELLOW_MS    = 2000,
  parameter int ALLRED_MS    = 1000,
  parameter int MS_W         = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       MS_TICK,
  input  logic       REQ_A,
  input  logic       REQ_B,
  output logic       GREEN_A,
  output logic       YELLOW_A,
  output logic       RED_A,
  output logic       GREEN_B,
  output logic       YELLOW_B,
  output logic       RED_B,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    S_INIT_RED = 3'd0,
    S_GREEN_A  = 3'd1,
    S_YELLOW_A = 3'd2,
    S_RED_AB   = 3'd3,
    S_GREEN_B  = 3'd4,
    S_YELLOW_B = 3'd5,
    S_RED_BA   = 3'd6,
    S_FLASH    = 3'd7
  } state_e;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamp_t;

  localparam logic [MS_W-1:0] MIN_T    = MS_W'(GREEN_MIN_MS);
  localparam logic [MS_W-1:0] MAX_T    = MS_W'(GREEN_MAX_MS);
  localparam logic [MS_W-1:0] YEL_T    = MS_W'(YELLOW_MS);
  localparam logic [MS_W-1:0] ALLRED_T = MS_W'(ALLRED_MS);
  localparam lamp_t LAMP_RED = '{green: 1'b0, yellow: 1'b0, red: 1'b1};
  localparam lamp_t LAMP_YEL = '{green: 1'b0, yellow: 1'b1, red: 1'b0};
  localparam lamp_t LAMP_GRN = '{green: 1'b1, yellow: 1'b0, red: 1'b0};

  state_e          state_q, state_d;
  logic [MS_W-1:0] timer_q, timer_d;
  logic            pend_a_q, pend_a_d;
  logic            pend_b_q, pend_b_d;
  lamp_t           lamp_a_q, lamp_a_d;
  lamp_t           lamp_b_q, lamp_b_d;
  logic            tick_en;
  logic [MS_W-1:0] elapsed;

`ifdef FLASH_YELLOW_EN
  localparam logic [MS_W-1:0] FLASH_HALF = MS_W'(500);
  logic flash_lit_q, flash_lit_d;
  logic flash_wrap;
`endif

  // Saturating phase timer; "elapsed" is the value after this tick's increment.
  always_comb begin
    tick_en = MS_TICK & EN;
    elapsed = (timer_q >= MAX_T) ? MAX_T : timer_q + MS_W'(1);
  end

  // Next-state: every exit is qualified by a counted tick, so EN low freezes sequencing.
  always_comb begin
    state_d = state_q;
    if (tick_en) begin
      case (state_q)
        S_INIT_RED: if (elapsed == ALLRED_T) state_d = S_GREEN_A;
        S_GREEN_A:
          if (pend_b_q && ((elapsed >= MIN_T && !REQ_A) || elapsed == MAX_T))
            state_d = S_YELLOW_A;
        S_YELLOW_A: if (elapsed == YEL_T)    state_d = S_RED_AB;
        S_RED_AB:   if (elapsed == ALLRED_T) state_d = S_GREEN_B;
        S_GREEN_B:
          if (pend_a_q && ((elapsed >= MIN_T && !REQ_B) || elapsed == MAX_T))
            state_d = S_YELLOW_B;
        S_YELLOW_B: if (elapsed == YEL_T)    state_d = S_RED_BA;
        S_RED_BA:   if (elapsed == ALLRED_T) state_d = S_GREEN_A;
        default:    state_d = S_INIT_RED;
      endcase
    end
`ifdef FLASH_YELLOW_EN
    if (!EN)                      state_d = S_FLASH;
    else if (state_q == S_FLASH)  state_d = S_INIT_RED;
`endif
  end

`ifdef FLASH_YELLOW_EN
  // In FLASH the timer counts raw ticks as a 500 ms half-period divider.
  always_comb begin
    flash_wrap  = MS_TICK && (timer_q + MS_W'(1) >= FLASH_HALF);
    flash_lit_d = flash_lit_q;
    if (state_q != S_FLASH) flash_lit_d = 1'b1;
    else if (flash_wrap)    flash_lit_d = ~flash_lit_q;
  end
`endif

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
`ifdef FLASH_YELLOW_EN
    else if (state_q == S_FLASH) begin
      if (flash_wrap)   timer_d = '0;
      else if (MS_TICK) timer_d = timer_q + MS_W'(1);
    end
`endif
    else if (tick_en) timer_d = elapsed;
  end

  // Requests latch outside own green; entering that green clears, overriding a same-cycle set.
  always_comb begin
    pend_a_d = pend_a_q | (REQ_A && state_q != S_GREEN_A);
    pend_b_d = pend_b_q | (REQ_B && state_q != S_GREEN_B);
    if (state_d == S_GREEN_A && state_q != S_GREEN_A) pend_a_d = 1'b0;
    if (state_d == S_GREEN_B && state_q != S_GREEN_B) pend_b_d = 1'b0;
  end

  // Lamps decoded from the next state so they change on the same edge as PHASE.
  always_comb begin
    lamp_a_d = LAMP_RED;
    lamp_b_d = LAMP_RED;
    case (state_d)
      S_GREEN_A:  lamp_a_d = LAMP_GRN;
      S_YELLOW_A: lamp_a_d = LAMP_YEL;
      S_GREEN_B:  lamp_b_d = LAMP_GRN;
      S_YELLOW_B: lamp_b_d = LAMP_YEL;
`ifdef FLASH_YELLOW_EN
      S_FLASH: begin
        lamp_a_d = '{green: 1'b0, yellow: flash_lit_d, red: 1'b0};
        lamp_b_d = '{green: 1'b0, yellow: flash_lit_d, red: 1'b0};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_INIT_RED;
      timer_q  <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      lamp_a_q <= LAMP_RED;
      lamp_b_q <= LAMP_RED;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      lamp_a_q <= lamp_a_d;
      lamp_b_q <= lamp_b_d;
    end
  end

`ifdef FLASH_YELLOW_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) flash_lit_q <= 1'b1;
    else      flash_lit_q <= flash_lit_d;
  end
`endif

  always_comb begin
    GREEN_A  = lamp_a_q.green;
    YELLOW_A = lamp_a_q.yellow;
    RED_A    = lamp_a_q.red;
    GREEN_B  = lamp_b_q.green;
    YELLOW_B = lamp_b_q.yellow;
    RED_B    = lamp_b_q.red;
    PHASE    = state_q;
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller (default build) with small timing parameters.
module tb_intersection_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b1;
  logic       MS_TICK = 1'b0;
  logic       REQ_A = 1'b0;
  logic       REQ_B = 1'b0;
  logic       GREEN_A, YELLOW_A, RED_A, GREEN_B, YELLOW_B, RED_B;
  logic [2:0] PHASE;

  int n_vec = 0;
  int n_err = 0;

  intersection_controller #(
    .GREEN_MIN_MS(5), .GREEN_MAX_MS(10), .YELLOW_MS(3), .ALLRED_MS(2), .MS_W(16)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MS_TICK(MS_TICK), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GREEN_A(GREEN_A), .YELLOW_A(YELLOW_A), .RED_A(RED_A),
    .GREEN_B(GREEN_B), .YELLOW_B(YELLOW_B), .RED_B(RED_B), .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Lamps packed as {G_A,Y_A,R_A,G_B,Y_B,R_B}
  function automatic int lamps();
    return {26'd0, GREEN_A, YELLOW_A, RED_A, GREEN_B, YELLOW_B, RED_B};
  endfunction

  // One MS_TICK per 4 clocks; returns on a negedge after the tick has been consumed.
  task automatic do_tick(input int n);
    repeat (n) begin
      @(negedge CLK); MS_TICK = 1'b1;
      @(negedge CLK); MS_TICK = 1'b0;
      repeat (2) @(negedge CLK);
    end
  endtask

  task automatic pulse_req(input logic a, input logic b);
    @(negedge CLK); REQ_A = a; REQ_B = b;
    @(negedge CLK); REQ_A = 1'b0; REQ_B = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b0; MS_TICK = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; EN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle: INIT_RED for 2 ticks then GREEN_A held.
    repeat (2) @(negedge CLK);
    chk("rst_phase", PHASE, 0);
    chk("rst_lamps", lamps(), 6'b001_001);
    RST = 1'b1;
    do_tick(1);
    chk("init_t1", PHASE, 0);
    do_tick(1);
    chk("init_to_ga", PHASE, 1);
    chk("ga_lamps", lamps(), 6'b100_001);
    do_tick(50);
    chk("ga_hold50", PHASE, 1);

    // REQ_B pulse at tick 1 of GREEN_A, REQ_A low: min-green handover.
    do_reset();
    do_tick(2);
    do_tick(1);
    pulse_req(1'b0, 1'b1);
    do_tick(3);
    chk("min_t4", PHASE, 1);
    do_tick(1);
    chk("min_ya", PHASE, 2);
    chk("ya_lamps", lamps(), 6'b010_001);
    do_tick(2);
    chk("ya_t2", PHASE, 2);
    do_tick(1);
    chk("rab", PHASE, 3);
    chk("rab_lamps", lamps(), 6'b001_001);
    do_tick(1);
    chk("rab_t1", PHASE, 3);
    do_tick(1);
    chk("gb", PHASE, 4);
    chk("gb_lamps", lamps(), 6'b001_100);
    chk("pend_b_clr", dut.pend_b_q, 0);
    do_tick(20);
    chk("gb_hold", PHASE, 4);

    // REQ_A held high with B pending: max-green after 10 ticks.
    do_reset();
    do_tick(2);
    REQ_A = 1'b1;
    @(negedge CLK); REQ_B = 1'b1;
    @(negedge CLK); REQ_B = 1'b0;
    do_tick(5);
    chk("max_t5", PHASE, 1);
    do_tick(4);
    chk("max_t9", PHASE, 1);
    do_tick(1);
    chk("max_ya", PHASE, 2);
    REQ_A = 1'b0;
    do_tick(3);
    do_tick(2);
    chk("max_gb", PHASE, 4);

    // EN low 20 ticks in GREEN_B with A pending: frozen, timer resumes afterwards.
    do_tick(2);
    EN = 1'b0;
    do_tick(20);
    chk("en_lo_phase", PHASE, 4);
    chk("en_lo_lamps", lamps(), 6'b001_100);
    EN = 1'b1;
    do_tick(2);
    chk("en_hi_t4", PHASE, 4);
    do_tick(1);
    chk("en_hi_yb", PHASE, 5);
    chk("yb_lamps", lamps(), 6'b001_010);
    do_tick(3);
    chk("rba", PHASE, 6);
    do_tick(2);
    chk("rba_ga", PHASE, 1);

    // Both requests in RED_AB: rotation gives B first, then back to A.
    pulse_req(1'b0, 1'b1);
    do_tick(5);
    chk("rot_ya", PHASE, 2);
    do_tick(3);
    chk("rot_rab", PHASE, 3);
    pulse_req(1'b1, 1'b1);
    do_tick(2);
    chk("rot_gb", PHASE, 4);
    do_tick(4);
    chk("rot_gb_t4", PHASE, 4);
    do_tick(1);
    chk("rot_yb", PHASE, 5);
    do_tick(3);
    chk("rot_rba", PHASE, 6);
    do_tick(1);
    chk("rot_rba_t1", PHASE, 6);
    do_tick(1);
    chk("rot_ga", PHASE, 1);

    // Asynchronous reset mid YELLOW_A: lamps go red before the next edge.
    pulse_req(1'b0, 1'b1);
    do_tick(5);
    chk("ar_ya", PHASE, 2);
    @(posedge CLK); #2;
    RST = 1'b0;
    #1;
    chk("ar_phase", PHASE, 0);
    chk("ar_lamps", lamps(), 6'b001_001);
    @(negedge CLK); RST = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
